// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised input, mid-bit sampling, and a level-valid /
// read-strobe handshake with one-cycle framing-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {BREAK, IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          s1, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          sample, commit, ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx_in;
      rx_s <= s1;
    end
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    commit    = 1'b0;
    ferr      = 1'b0;
    case (state)
      BREAK: if (rx_s) state_nxt = IDLE;
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (cnt == HALF_M1) state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (cnt == FULL_M1) begin
          sample = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          if (rx_s) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      default: state_nxt = BREAK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BREAK;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_busy      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      // Zero on each bit sample too, so non-power-of-two bit periods wrap correctly.
      if (state_nxt != state || sample || state == IDLE || state == BREAK)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state == START) bit_idx <= '0;
      if (sample) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      rx_busy      <= (state_nxt inside {START, DATA, STOP});
      rx_frame_err <= ferr;

      if (rx_read && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      // A read in the same cycle frees the holding register, so the new byte is kept.
      if (commit) begin
        if (!rx_valid || rx_read) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (C=16): frame timing, false start, framing error,
// overrun, read/commit collision, mid-frame reset and back-to-back frames.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset, rx_in, rx_read;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err, rx_overrun;

  int compared   = 0;
  int mismatched = 0;
  int ferr_count = 0;
  int ferr_base;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .rx_read(rx_read),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_frame_err === 1'b1) ferr_count++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit plus 8 data bits, 16 cycles each; rx_read is dropped after one cycle.
  task automatic send_head(input logic [7:0] b);
    rx_in = 1'b0;
    tick(1);
    rx_read = 1'b0;
    tick(15);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_head(b);
    rx_in = stop_bit;
    tick(16);
  endtask

  task automatic read_pulse();
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_in = 1'b1; rx_read = 1'b0;
    tick(3);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    chk("reset_ferr", rx_frame_err, 1'b0);
    chk("reset_ovr", rx_overrun, 1'b0);
    reset = 1'b0;
    tick(5);

    // 1: 0xA5 with latency check; start driven after edge k, valid rises at k+155
    send_head(8'hA5);
    rx_in = 1'b1;
    tick(10);
    chk("t1_valid_before", rx_valid, 1'b0);
    chk("t1_busy_stop", rx_busy, 1'b1);
    tick(1);
    chk("t1_valid_edge", rx_valid, 1'b1);
    chk("t1_data", rx_data, 8'hA5);
    tick(5);
    chk("t1_no_ferr", ferr_count, 0);
    read_pulse();
    chk("t1_read_clears", rx_valid, 1'b0);

    // 2: 4-cycle glitch is a false start
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(30);
    chk("t2_busy", rx_busy, 1'b0);
    chk("t2_valid", rx_valid, 1'b0);
    chk("t2_ovr", rx_overrun, 1'b0);
    chk("t2_ferr", ferr_count, 0);
    send_frame(8'h3C, 1'b1);
    chk("t2_data", rx_data, 8'h3C);
    chk("t2_valid_after", rx_valid, 1'b1);
    read_pulse();
    tick(4);

    // 3: stop bit low, line held low -> single framing error, stays in BREAK
    ferr_base = ferr_count;
    send_frame(8'h3C, 1'b0);
    tick(40);
    chk("t3_ferr_once", ferr_count - ferr_base, 1);
    chk("t3_valid", rx_valid, 1'b0);
    chk("t3_break_not_busy", rx_busy, 1'b0);
    chk("t3_data_kept", rx_data, 8'h3C);
    rx_in = 1'b1;
    tick(8);
    send_frame(8'h81, 1'b1);
    chk("t3_next_data", rx_data, 8'h81);
    chk("t3_next_valid", rx_valid, 1'b1);
    read_pulse();
    tick(4);

    // 4: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("t4_data", rx_data, 8'h11);
    chk("t4_ovr", rx_overrun, 1'b1);
    chk("t4_valid", rx_valid, 1'b1);
    read_pulse();
    chk("t4_read_valid", rx_valid, 1'b0);
    chk("t4_read_ovr", rx_overrun, 1'b0);
    tick(4);

    // 5: read coincident with commit
    send_frame(8'h11, 1'b1);
    send_head(8'h22);
    rx_in = 1'b1;
    tick(10);
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
    chk("t5_data", rx_data, 8'h22);
    chk("t5_valid", rx_valid, 1'b1);
    chk("t5_ovr", rx_overrun, 1'b0);
    tick(5);

    // 6: reset mid-frame with unread byte pending
    rx_in = 1'b0;
    tick(16);
    rx_in = 1'b1;
    tick(48);
    chk("t6_busy_pre", rx_busy, 1'b1);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_data", rx_data, 8'h00);
    chk("t6_rst_valid", rx_valid, 1'b0);
    chk("t6_rst_busy", rx_busy, 1'b0);
    chk("t6_rst_ferr", rx_frame_err, 1'b0);
    chk("t6_rst_ovr", rx_overrun, 1'b0);
    reset = 1'b0;
    tick(20);
    send_frame(8'h5A, 1'b1);
    chk("t6_data", rx_data, 8'h5A);
    read_pulse();
    tick(4);
    send_frame(8'h00, 1'b1);
    chk("t6_b2b_first_valid", rx_valid, 1'b1);
    chk("t6_b2b_first_data", rx_data, 8'h00);
    rx_read = 1'b1;
    send_frame(8'hFF, 1'b1);
    chk("t6_b2b_second_data", rx_data, 8'hFF);
    chk("t6_b2b_second_valid", rx_valid, 1'b1);
    chk("t6_b2b_ovr", rx_overrun, 1'b0);
    chk("t6_no_extra_ferr", ferr_count - ferr_base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
